// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage
//   RV32I decode stage between the IFU and the EXU. Each instruction is decoded
//   into the 4-bit ALU operation select, the operand-source selects and the
//   sign-extended immediate. The result is held in a registered output slot (M)
//   backed by a one-entry skid slot (S). This keeps full throughput while
//   in_ready comes straight from a flop.
//
// Handshake: a beat moves on a port when valid and ready are both high at a
//   rising clk edge. A producer holding valid keeps its payload stable until the
//   beat moves. out_* stay stable while out_valid & !out_ready. flush and rst_n
//   take priority over both handshakes, and an input offered in that cycle is
//   dropped.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   flush              kills every held entry (redirect)
//   in_valid/in_ready  upstream handshake; in_ready is registered
//   in_instr, in_pc    instruction word and its PC
//   out_valid/out_ready downstream handshake
//   out_alu_ctr        ALU op select
//   out_src_a          0 = rs1, 1 = PC
//   out_src_b          0 = rs2, 1 = imm, 2 = constant 4
//   out_imm            sign-extended immediate (0 for R-type and illegal)
//   out_pc             PC passed through
//   out_illegal        unsupported opcode/funct encoding
module alu_ctrl_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctr,
  output logic             out_src_a,
  output logic [1:0]       out_src_b,
  output logic [WIDTH-1:0] out_imm,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_COPY = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  typedef struct packed {
    logic [3:0]       alu_ctr;
    logic             src_a;
    logic [1:0]       src_b;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic             illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
  // Shift-immediates carry only the shamt; funct7 is an opcode extension.
  assign imm_shamt = {27'b0, in_instr[24:20]};

  logic [3:0]  dec_alu;
  logic        dec_src_a;
  logic [1:0]  dec_src_b;
  logic [31:0] dec_imm;
  logic        dec_bad;
  entry_t      dec;

  always_comb begin
    dec_alu   = ALU_ADD;
    dec_src_a = 1'b0;
    dec_src_b = SRC_B_RS2;
    dec_imm   = 32'b0;
    dec_bad   = 1'b0;
    // The opcode match also covers instr[1:0] == 2'b11.
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00) begin
          unique case (funct3)
            3'b000:  dec_alu = ALU_ADD;
            3'b001:  dec_alu = ALU_SLL;
            3'b010:  dec_alu = ALU_SLT;
            3'b011:  dec_alu = ALU_SLTU;
            3'b100:  dec_alu = ALU_XOR;
            3'b101:  dec_alu = ALU_SRL;
            3'b110:  dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          dec_alu = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          dec_alu = ALU_SRA;
        end else begin
          dec_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_src_b = SRC_B_IMM;
        dec_imm   = imm_i;
        unique case (funct3)
          3'b000:  dec_alu = ALU_ADD;
          3'b010:  dec_alu = ALU_SLT;
          3'b011:  dec_alu = ALU_SLTU;
          3'b100:  dec_alu = ALU_XOR;
          3'b110:  dec_alu = ALU_OR;
          3'b111:  dec_alu = ALU_AND;
          3'b001: begin
            dec_alu = ALU_SLL;
            dec_imm = imm_shamt;
            dec_bad = (funct7 != 7'h00);
          end
          default: begin
            dec_alu = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            dec_imm = imm_shamt;
            dec_bad = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        endcase
      end
      OPC_LUI: begin
        dec_alu   = ALU_COPY;
        dec_src_b = SRC_B_IMM;
        dec_imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec_src_a = 1'b1;
        dec_src_b = SRC_B_IMM;
        dec_imm   = imm_u;
      end
      OPC_LOAD: begin
        dec_src_b = SRC_B_IMM;
        dec_imm   = imm_i;
      end
      OPC_STORE: begin
        dec_src_b = SRC_B_IMM;
        dec_imm   = imm_s;
      end
      OPC_BRANCH: begin
        // Compare rs1 against rs2; the B immediate feeds the target adder.
        dec_imm = imm_b;
        unique case (funct3[2:1])
          2'b00:   dec_alu = ALU_SUB;
          2'b10:   dec_alu = ALU_SLT;
          2'b11:   dec_alu = ALU_SLTU;
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        // The ALU computes the link value PC+4.
        dec_src_a = 1'b1;
        dec_src_b = SRC_B_FOUR;
        dec_imm   = imm_j;
      end
      OPC_JALR: begin
        dec_src_a = 1'b1;
        dec_src_b = SRC_B_FOUR;
        dec_imm   = imm_i;
        dec_bad   = (funct3 != 3'b000);
      end
      default: dec_bad = 1'b1;
    endcase
    // Illegal entries carry a clean all-zero control payload.
    if (dec_bad) begin
      dec_alu   = ALU_ADD;
      dec_src_a = 1'b0;
      dec_src_b = SRC_B_RS2;
      dec_imm   = 32'b0;
    end
  end

  assign dec = '{alu_ctr: dec_alu, src_a: dec_src_a, src_b: dec_src_b,
                 imm: dec_imm, pc: in_pc, illegal: dec_bad};

  // ---------------------------------------------------------------------------
  // Main slot M and skid slot S
  // ---------------------------------------------------------------------------
  entry_t m_q, s_q;
  logic   m_valid, s_valid, ready_q;
  logic   in_xfer, m_free, s_next;

  assign in_xfer = in_valid & ready_q & ~flush;
  assign m_free  = ~m_valid | out_ready;

  // S stays occupied when M drains into the next entry while a new one arrives,
  // and fills when M is stalled and an input is accepted.
  always_comb begin
    s_next = s_valid;
    if (s_valid) s_next = ~m_free | in_xfer;
    else         s_next = ~m_free & in_xfer;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b1;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (m_free) begin
        if (s_valid) begin
          m_q     <= s_q;
          m_valid <= 1'b1;
          if (in_xfer) s_q <= dec;
        end else if (in_xfer) begin
          m_q     <= dec;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        s_q <= dec;
      end
      s_valid <= s_next;
      ready_q <= ~s_next;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = m_valid;
  assign out_alu_ctr = m_q.alu_ctr;
  assign out_src_a   = m_q.src_a;
  assign out_src_b   = m_q.src_b;
  assign out_imm     = m_q.imm;
  assign out_pc      = m_q.pc;
  assign out_illegal = m_q.illegal;

endmodule
